// File: rtl/pipelined_pg_adder_pkg.sv
// +----------------------------------------------------------------------+
// | fpu_adder_pkg : shared constants, stage-count helper, stage control  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fpu_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int pg_stages(input int swr, input int seg);
    return (swr + seg - 1) / seg;
  endfunction

  // Control half of a stage bundle; sum/prop/skewed operands are sized per stage in the top
  typedef struct packed {
    logic valid;
    logic carry;
  } pg_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipelined_pg_adder_if.sv
// +----------------------------------------------------------------------+
// | pipelined_pg_adder_if : operand/result handshake bundle              |
// | Rev 1.0   (P_o present with PGADD_PROPAGATE_OUT_EN)                  |
// +----------------------------------------------------------------------+
`default_nettype none

interface pipelined_pg_adder_if #(
  parameter int SWR = 26
);
  logic           valid_i;
  logic           ready_o;
  logic           op_i;
  logic [SWR-1:0] Op_A_i;
  logic [SWR-1:0] Op_B_i;
  logic           C_i;
  logic           valid_o;
  logic           ready_i;
  logic [SWR-1:0] S_o;
  logic           C_o;
`ifdef PGADD_PROPAGATE_OUT_EN
  logic [SWR-1:0] P_o;
`endif

  modport slave (
    input  valid_i, op_i, Op_A_i, Op_B_i, C_i, ready_i,
`ifdef PGADD_PROPAGATE_OUT_EN
    output P_o,
`endif
    output ready_o, valid_o, S_o, C_o
  );

  modport master (
    output valid_i, op_i, Op_A_i, Op_B_i, C_i, ready_i,
`ifdef PGADD_PROPAGATE_OUT_EN
    input  P_o,
`endif
    input  ready_o, valid_o, S_o, C_o
  );

endinterface

`default_nettype wire

// File: rtl/pipelined_pg_adder_segment.sv
// +----------------------------------------------------------------------+
// | pg_adder_segment : W-bit ripple adder built from 1-bit PG cells      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pg_full_adder (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_cin,
  output logic      o_s,
  output logic      o_cout,
  output logic      o_p
);
  logic w_g;

  assign o_p    = i_a ^ i_b;
  assign w_g    = i_a & i_b;
  assign o_s    = o_p ^ i_cin;
  assign o_cout = w_g | (o_p & i_cin);
endmodule

module pg_adder_segment #(
  parameter int W = 14
) (
  input  wire logic [W-1:0] a,
  input  wire logic [W-1:0] b,
  input  wire logic         cin,
  output logic [W-1:0]      sum,
  output logic              cout,
  output logic [W-1:0]      p
);
  logic [W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    pg_full_adder u_fa (
      .i_a    (a[i]),
      .i_b    (b[i]),
      .i_cin  (w_c[i]),
      .o_s    (sum[i]),
      .o_cout (w_c[i+1]),
      .o_p    (p[i])
    );
  end

  assign cout = w_c[W];
endmodule

`default_nettype wire

// File: rtl/pipelined_pg_adder.sv
// +----------------------------------------------------------------------+
// | pipelined_pg_adder : segmented pipelined PG add/sub, valid/ready     |
// | Rev 1.0   (define PGADD_PROPAGATE_OUT_EN for the P_o output)         |
// +----------------------------------------------------------------------+
`default_nettype none

module pipelined_pg_adder
  import fpu_adder_pkg::*;
#(
  parameter int SWR = 26,
  parameter int SEG = 14
) (
  input  wire logic              clk,
  input  wire logic              rst,
  pipelined_pg_adder_if.slave    bus
);

  localparam int STAGES = pg_stages(SWR, SEG);
  localparam int LAST   = STAGES - 1;

  logic w_en;

  assign w_en        = bus.ready_i | ~bus.valid_o;
  assign bus.ready_o = w_en;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * SEG;
    localparam int HI = ((s + 1) * SEG > SWR) ? SWR : (s + 1) * SEG;
    localparam int W  = HI - LO;

    // Low W bits of the incoming operands are this segment; the rest stay pending
    logic [SWR-LO-1:0] w_a_in;
    logic [SWR-LO-1:0] w_b_in;
    logic              w_cin;
    logic              w_v_in;
    logic [W-1:0]      w_sum;
    logic              w_cout;
    pg_ctrl_t          w_ctrl_nxt;
    pg_ctrl_t          r_ctrl;
    logic [HI-1:0]     r_sum;
`ifdef PGADD_PROPAGATE_OUT_EN
    logic [W-1:0]      w_p;
    logic [HI-1:0]     r_p;
`else
    logic [W-1:0]      w_p_unused;
`endif

    pg_adder_segment #(.W(W)) u_seg (
      .a    (w_a_in[W-1:0]),
      .b    (w_b_in[W-1:0]),
      .cin  (w_cin),
      .sum  (w_sum),
      .cout (w_cout),
`ifdef PGADD_PROPAGATE_OUT_EN
      .p    (w_p)
`else
      .p    (w_p_unused)
`endif
    );

    assign w_ctrl_nxt.valid = w_v_in;
    assign w_ctrl_nxt.carry = w_cout;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_ctrl <= '0;
      end else if (w_en) begin
        r_ctrl <= w_ctrl_nxt;
      end
    end

    if (s == 0) begin : g_head
      assign w_a_in = bus.Op_A_i;
      assign w_b_in = (bus.op_i == OP_SUB) ? ~bus.Op_B_i : bus.Op_B_i;
      assign w_cin  = (bus.op_i == OP_SUB) ? 1'b1 : bus.C_i;
      assign w_v_in = bus.valid_i;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_sum <= '0;
`ifdef PGADD_PROPAGATE_OUT_EN
          r_p   <= '0;
`endif
        end else if (w_en) begin
          r_sum <= w_sum;
`ifdef PGADD_PROPAGATE_OUT_EN
          r_p   <= w_p;
`endif
        end
      end
    end else begin : g_body
      assign w_a_in = g_stage[s-1].g_pend.r_a;
      assign w_b_in = g_stage[s-1].g_pend.r_b;
      assign w_cin  = g_stage[s-1].r_ctrl.carry;
      assign w_v_in = g_stage[s-1].r_ctrl.valid;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_sum <= '0;
`ifdef PGADD_PROPAGATE_OUT_EN
          r_p   <= '0;
`endif
        end else if (w_en) begin
          r_sum <= {w_sum, g_stage[s-1].r_sum};
`ifdef PGADD_PROPAGATE_OUT_EN
          r_p   <= {w_p, g_stage[s-1].r_p};
`endif
        end
      end
    end

    if (s < LAST) begin : g_pend
      logic [SWR-HI-1:0] r_a;
      logic [SWR-HI-1:0] r_b;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_in[SWR-LO-1:W];
          r_b <= w_b_in[SWR-LO-1:W];
        end
      end
    end
  end

  assign bus.valid_o = g_stage[LAST].r_ctrl.valid;
  assign bus.C_o     = g_stage[LAST].r_ctrl.carry;
  assign bus.S_o     = g_stage[LAST].r_sum;
`ifdef PGADD_PROPAGATE_OUT_EN
  assign bus.P_o     = g_stage[LAST].r_p;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_pg_adder.sv
// +----------------------------------------------------------------------+
// | tb_pipelined_pg_adder : directed/random checks over four SEG values  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipelined_pg_adder;
  import fpu_adder_pkg::*;

  localparam int SWR = 26;
  localparam int ND  = 4;
  localparam int SEG_TAB [ND] = '{14, 1, 7, 26};
  localparam int STG     [ND] = '{2, 26, 4, 1};
  localparam int NV  = 12;

  typedef struct packed {
    logic [SWR-1:0] s;
    logic           c;
    logic [SWR-1:0] p;
    logic [31:0]    cyc;
  } exp_t;

  typedef struct packed {
    logic           op;
    logic [SWR-1:0] a;
    logic [SWR-1:0] b;
    logic           ci;
    logic [SWR-1:0] s;
    logic           c;
    logic [SWR-1:0] p;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           r_valid = 1'b0;
  logic           r_op = 1'b0;
  logic           r_ci = 1'b0;
  logic           r_ready = 1'b1;
  logic           r_sweep = 1'b1;
  logic [SWR-1:0] r_a = '0;
  logic [SWR-1:0] r_b = '0;
  exp_t           cur_exp;
  logic           lat_chk = 1'b0;
  logic           acc0 = 1'b0;
  logic           hold = 1'b0;
  logic [SWR-1:0] hold_s;
  logic           hold_c;
  int             n_checks = 0;
  int             n_fail = 0;
  int             cyc = 0;
  exp_t           mem [ND][1024];
  int             wr [ND];
  int             rd [ND];
  vec_t           tbl [NV];

  logic           vo [ND];
  logic           ro [ND];
  logic           co [ND];
  logic [SWR-1:0] so [ND];
  logic [SWR-1:0] po [ND];

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    pipelined_pg_adder_if #(.SWR(SWR)) bus ();

    pipelined_pg_adder #(.SWR(SWR), .SEG(SEG_TAB[d])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    assign bus.valid_i = (d == 0) ? r_valid : (r_valid & r_sweep);
    assign bus.ready_i = (d == 0) ? r_ready : 1'b1;
    assign bus.op_i    = r_op;
    assign bus.Op_A_i  = r_a;
    assign bus.Op_B_i  = r_b;
    assign bus.C_i     = r_ci;
    assign vo[d]       = bus.valid_o;
    assign ro[d]       = bus.ready_o;
    assign co[d]       = bus.C_o;
    assign so[d]       = bus.S_o;
`ifdef PGADD_PROPAGATE_OUT_EN
    assign po[d]       = bus.P_o;
`else
    assign po[d]       = '0;
`endif
  end

  function automatic exp_t model(input logic op, input logic [SWR-1:0] a,
                                 input logic [SWR-1:0] b, input logic ci);
    logic [SWR-1:0] bb;
    logic [SWR:0]   t;
    exp_t           e;
    bb    = op ? ~b : b;
    t     = {1'b0, a} + {1'b0, bb} + {{SWR{1'b0}}, (op ? 1'b1 : ci)};
    e.s   = t[SWR-1:0];
    e.c   = t[SWR];
    e.p   = a ^ bb;
    e.cyc = '0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Called at a falling edge with inputs set; logs accepts, checks drains, advances one cycle
  task automatic step();
    logic v;
    logic r;
    exp_t e;
    #1;
    for (int d = 0; d < ND; d++) begin
      v = (d == 0) ? r_valid : (r_valid & r_sweep);
      r = (d == 0) ? r_ready : 1'b1;
      if (d == 0) acc0 = v & ro[d];
      if (v && ro[d]) begin
        e = cur_exp;
        e.cyc = cyc;
        mem[d][wr[d] % 1024] = e;
        wr[d]++;
      end
      if (vo[d] && r) begin
        check($sformatf("dut%0d beat expected", d), 64'(wr[d] > rd[d]), 64'd1);
        if (wr[d] > rd[d]) begin
          e = mem[d][rd[d] % 1024];
          rd[d]++;
          check($sformatf("dut%0d S_o", d), 64'(so[d]), 64'(e.s));
          check($sformatf("dut%0d C_o", d), 64'(co[d]), 64'(e.c));
`ifdef PGADD_PROPAGATE_OUT_EN
          check($sformatf("dut%0d P_o", d), 64'(po[d]), 64'(e.p));
`endif
          if (lat_chk)
            check($sformatf("dut%0d latency", d), 64'(cyc - int'(e.cyc)), 64'(STG[d]));
        end
      end
    end
    if (hold) begin
      check("stall valid_o", 64'(vo[0]), 64'd1);
      check("stall S_o", 64'(so[0]), 64'(hold_s));
      check("stall C_o", 64'(co[0]), 64'(hold_c));
    end
    hold   = vo[0] & ~r_ready;
    hold_s = so[0];
    hold_c = co[0];
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_beat();
    r_op = 1'($urandom_range(0, 1));
    r_a  = SWR'($urandom);
    r_b  = SWR'($urandom);
    r_ci = 1'($urandom_range(0, 1));
    cur_exp = model(r_op, r_a, r_b, r_ci);
  endtask

  initial begin
    //          op     A             B             Ci    S             C     P
    tbl[0]  = '{OP_ADD, 26'h3FFFFFF, 26'h0000001, 1'b0, 26'h0000000, 1'b1, 26'h3FFFFFE};
    tbl[1]  = '{OP_SUB, 26'h0000100, 26'h0000001, 1'b0, 26'h00000FF, 1'b1, 26'h3FFFEFE};
    tbl[2]  = '{OP_SUB, 26'h0000001, 26'h0000002, 1'b0, 26'h3FFFFFF, 1'b0, 26'h3FFFFFC};
    tbl[3]  = '{OP_ADD, 26'h0000000, 26'h0000000, 1'b1, 26'h0000001, 1'b0, 26'h0000000};
    tbl[4]  = '{OP_ADD, 26'h3FFFFFF, 26'h3FFFFFF, 1'b1, 26'h3FFFFFF, 1'b1, 26'h0000000};
    tbl[5]  = '{OP_SUB, 26'h0000005, 26'h0000005, 1'b0, 26'h0000000, 1'b1, 26'h3FFFFFF};
    tbl[6]  = '{OP_ADD, 26'h0002000, 26'h0002000, 1'b0, 26'h0004000, 1'b0, 26'h0000000};
    tbl[7]  = '{OP_SUB, 26'h0000000, 26'h0000000, 1'b1, 26'h0000000, 1'b1, 26'h3FFFFFF};
    tbl[8]  = '{OP_ADD, 26'h1555555, 26'h2AAAAAA, 1'b1, 26'h0000000, 1'b1, 26'h3FFFFFF};
    tbl[9]  = '{OP_SUB, 26'h0000000, 26'h0000001, 1'b0, 26'h3FFFFFF, 1'b0, 26'h3FFFFFE};
    tbl[10] = '{OP_ADD, 26'h2000000, 26'h2000000, 1'b0, 26'h0000000, 1'b1, 26'h0000000};
    tbl[11] = '{OP_ADD, 26'h0123456, 26'h0654321, 1'b0, 26'h0777777, 1'b0, 26'h0777777};

    for (int d = 0; d < ND; d++) begin
      wr[d] = 0;
      rd[d] = 0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d reset valid_o", d), 64'(vo[d]), 64'd0);
      check($sformatf("dut%0d reset S_o", d), 64'(so[d]), 64'd0);
      check($sformatf("dut%0d reset C_o", d), 64'(co[d]), 64'd0);
      check($sformatf("dut%0d reset ready_o", d), 64'(ro[d]), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed table, one beat at a time with exact latency
    lat_chk = 1'b1;
    for (int i = 0; i < NV; i++) begin
      r_op = tbl[i].op;
      r_a  = tbl[i].a;
      r_b  = tbl[i].b;
      r_ci = tbl[i].ci;
      cur_exp.s = tbl[i].s;
      cur_exp.c = tbl[i].c;
      cur_exp.p = tbl[i].p;
      r_valid = 1'b1;
      step();
      r_valid = 1'b0;
      repeat (30) step();
    end

    // Back-to-back random stream
    for (int i = 0; i < 100; i++) begin
      rand_beat();
      r_valid = 1'b1;
      step();
    end
    r_valid = 1'b0;
    repeat (30) step();

    // Random backpressure on the SEG=14 instance only
    lat_chk = 1'b0;
    r_sweep = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!r_valid || acc0) begin
        rand_beat();
        r_valid = ($urandom_range(0, 2) != 0);
      end
      r_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    r_valid = 1'b0;
    r_ready = 1'b1;
    repeat (30) step();

    // Reset with beats in flight, then one fresh beat
    r_sweep = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_beat();
      r_valid = 1'b1;
      step();
    end
    r_valid = 1'b0;
    rst = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d async reset valid_o", d), 64'(vo[d]), 64'd0);
      rd[d] = wr[d];
    end
    check("async reset S_o", 64'(so[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    r_op = OP_ADD;
    r_a  = 26'h0ABCDEF;
    r_b  = 26'h1000000;
    r_ci = 1'b1;
    cur_exp.s = 26'h1ABCDF0;
    cur_exp.c = 1'b0;
    cur_exp.p = 26'h1ABCDEF;
    r_valid = 1'b1;
    step();
    r_valid = 1'b0;
    repeat (30) step();

    for (int d = 0; d < ND; d++)
      check($sformatf("dut%0d all beats drained", d), 64'(rd[d]), 64'(wr[d]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
